// File: rtl/taxi_qsfp_mgmt_ctrl.sv
// taxi_qsfp_mgmt_ctrl: QSFP28 presence debounce, timed power-up sequencing and MAC lane gating
module taxi_qsfp_mgmt_ctrl #(
  parameter int CNT             = 4,
  parameter int DEBOUNCE_CYCLES = 1250,
  parameter int RESET_CYCLES    = 1250,
  parameter int INIT_CYCLES     = 250000000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           restart,
  input  logic [CNT-1:0] lane_enable,
  input  logic           qsfp_modprsl,
  input  logic           qsfp_intl,
  input  logic [CNT-1:0] rx_status,
  output logic           qsfp_resetl,
  output logic           qsfp_lpmode,
  output logic           qsfp_modsell,
  output logic           mac_rst,
  output logic [CNT-1:0] cfg_tx_enable,
  output logic [CNT-1:0] cfg_rx_enable,
  output logic [CNT-1:0] link_up,
  output logic           present,
  output logic           int_event,
  output logic [2:0]     state
);
  localparam int RC = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;
  localparam int IC = (INIT_CYCLES < 1) ? 1 : INIT_CYCLES;
  localparam int MX = (RC > IC) ? RC : IC;
  localparam int TW = $clog2(MX + 1);
  localparam int DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int DW = $clog2(DB + 1);
  localparam logic [TW-1:0] R_LOAD = TW'(RC - 1);
  localparam logic [TW-1:0] I_LOAD = TW'(IC - 1);
  typedef enum logic [2:0] {
    S_DISABLED = 3'd0,
    S_ABSENT   = 3'd1,
    S_RESET    = 3'd2,
    S_INIT     = 3'd3,
    S_ACTIVE   = 3'd4
  } state_t;
  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      modprsl_sync_q, intl_sync_q;
  logic [CNT-1:0]  rx_sync0_q, rx_sync1_q;
  logic            intl_prev_q;
  logic            modprsl_s, intl_s;
  logic [DW-1:0]   db_cnt_q, db_cnt_d, db_inc;
  logic            present_q, present_d;
  logic            resetl_q, resetl_d, lpmode_q, lpmode_d, modsell_q, modsell_d;
  logic            mac_rst_q, mac_rst_d, int_q, int_d;
  logic [CNT-1:0]  en_q, en_d, link_q, link_d;
  logic            act_d, up_d;
  assign modprsl_s = modprsl_sync_q[1];
  assign intl_s    = intl_sync_q[1];
  // synchronisers idle at the inactive level so reset never looks like an insert or interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      modprsl_sync_q <= 2'b11;
      intl_sync_q    <= 2'b11;
      intl_prev_q    <= 1'b1;
      rx_sync0_q     <= '0;
      rx_sync1_q     <= '0;
    end else begin
      modprsl_sync_q <= {modprsl_sync_q[0], qsfp_modprsl};
      intl_sync_q    <= {intl_sync_q[0], qsfp_intl};
      intl_prev_q    <= intl_s;
      rx_sync0_q     <= rx_status;
      rx_sync1_q     <= rx_sync0_q;
    end
  end
  assign db_inc = db_cnt_q + 1'b1;
  always_comb begin
    present_d = present_q;
    db_cnt_d  = '0;
    if (modprsl_s == present_q) begin
      if (db_inc == DW'(DB)) present_d = !present_q;
      else db_cnt_d = db_inc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      present_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      present_q <= present_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DISABLED;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end
  always_comb begin
    state_d = state_q;
    timer_d = ((state_q == S_RESET || state_q == S_INIT) && timer_q != '0) ? timer_q - 1'b1 : timer_q;
    if (!enable) begin
      state_d = S_DISABLED;
    end else if (!present_q && state_q != S_DISABLED) begin
      state_d = S_ABSENT;
    end else if (restart && (state_q == S_RESET || state_q == S_INIT || state_q == S_ACTIVE)) begin
      state_d = S_RESET;
      timer_d = R_LOAD;
    end else begin
      case (state_q)
        S_DISABLED: state_d = S_ABSENT;
        S_ABSENT: begin
          state_d = S_RESET;
          timer_d = R_LOAD;
        end
        S_RESET: if (timer_q == '0) begin
          state_d = S_INIT;
          timer_d = I_LOAD;
        end
        S_INIT:   state_d = (timer_q == '0) ? S_ACTIVE : S_INIT;
        S_ACTIVE: state_d = S_ACTIVE;
        default:  state_d = S_DISABLED;
      endcase
    end
  end
  // pins are decoded from the next state so they move on the same edge as state
  always_comb begin
    act_d     = (state_d == S_ACTIVE);
    up_d      = act_d || (state_d == S_INIT);
    resetl_d  = up_d;
    lpmode_d  = !act_d;
    modsell_d = !up_d;
    mac_rst_d = !act_d;
    en_d      = act_d ? lane_enable : '0;
    link_d    = act_d ? (rx_sync1_q & lane_enable) : '0;
    int_d     = act_d && intl_prev_q && !intl_s;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resetl_q  <= 1'b0;
      lpmode_q  <= 1'b1;
      modsell_q <= 1'b1;
      mac_rst_q <= 1'b1;
      en_q      <= '0;
      link_q    <= '0;
      int_q     <= 1'b0;
    end else begin
      resetl_q  <= resetl_d;
      lpmode_q  <= lpmode_d;
      modsell_q <= modsell_d;
      mac_rst_q <= mac_rst_d;
      en_q      <= en_d;
      link_q    <= link_d;
      int_q     <= int_d;
    end
  end
  assign qsfp_resetl   = resetl_q;
  assign qsfp_lpmode   = lpmode_q;
  assign qsfp_modsell  = modsell_q;
  assign mac_rst       = mac_rst_q;
  assign cfg_tx_enable = en_q;
  assign cfg_rx_enable = en_q;
  assign link_up       = link_q;
  assign present       = present_q;
  assign int_event     = int_q;
  assign state         = state_q;
endmodule

// File: doc/taxi_qsfp_mgmt_ctrl.md
# taxi_qsfp_mgmt_ctrl

QSFP28 module management sequencer for the 4-lane 25G MAC/PHY path. Debounces module presence, drives the module sideband pins (ResetL, LPMode, ModSelL) through a timed power-up sequence, and gates the MAC reset and per-lane TX/RX enables so traffic runs only on a fully initialised module. Sits in the control-clock domain between the board QSFP pins and the `taxi_eth_mac_25g_us` configuration/reset inputs.

## Interface
Parameters:
- `CNT`, 4: number of MAC lanes.
- `DEBOUNCE_CYCLES`, 1250: consecutive stable samples of synchronised ModPrsL required to change `present`; minimum 1.
- `RESET_CYCLES`, 1250: cycles ResetL is held low in RESET; 0 is treated as 1.
- `INIT_CYCLES`, 250000000: module init wait (t_init) in INIT; 0 is treated as 1.

Ports:
- `clk`  in  1  control clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `enable`  in  1  software enable; 0 forces DISABLED.
- `restart`  in  1  single-cycle request to re-run the reset sequence.
- `lane_enable`  in  CNT  per-lane enable mask.
- `qsfp_modprsl`  in  1  module present, active-low, asynchronous.
- `qsfp_intl`  in  1  module interrupt, active-low, asynchronous.
- `rx_status`  in  CNT  per-lane MAC RX link status, asynchronous.
- `qsfp_resetl`  out  1  module reset, active-low.
- `qsfp_lpmode`  out  1  module low-power mode.
- `qsfp_modsell`  out  1  module select, active-low.
- `mac_rst`  out  1  reset to MAC/transceiver.
- `cfg_tx_enable`  out  CNT  per-lane MAC TX enable.
- `cfg_rx_enable`  out  CNT  per-lane MAC RX enable.
- `link_up`  out  CNT  per-lane link qualified by ACTIVE.
- `present`  out  1  debounced presence.
- `int_event`  out  1  one-cycle pulse on module interrupt.
- `state`  out  3  current state encoding.

## Operation
- Input sync: `qsfp_modprsl`, `qsfp_intl` and each `rx_status` bit each pass through a 2-flop synchroniser. Synchroniser flops reset to the inactive level: 1 for ModPrsL/IntL, 0 for rx_status.
- Debounce:
  - Counter clears whenever synced ModPrsL equals the current `present` polarity (i.e. `!modprsl_s == present`).
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES, `present` toggles and the counter clears.
- States (`state` encoding): DISABLED=0, ABSENT=1, RESET=2, INIT=3, ACTIVE=4.
- Transition priority, evaluated every cycle:
  1. `enable`=0 -> DISABLED.
  2. Otherwise, `present`=0 in any state other than DISABLED -> ABSENT.
  3. Otherwise, `restart`=1 in RESET, INIT or ACTIVE -> RESET, counter reloaded.
  4. Otherwise, normal progression.
- Normal progression:
  - DISABLED -> ABSENT when `enable`=1.
  - ABSENT -> RESET when `present`=1; timer loads RESET_CYCLES-1.
  - RESET -> INIT when timer=0; timer loads INIT_CYCLES-1.
  - INIT -> ACTIVE when timer=0.
  - Timer decrements once per cycle in RESET and INIT; it is sized `$clog2(max(RESET_CYCLES,INIT_CYCLES)+1)`, saturates at 0 and never wraps.
- Outputs, registered and decoded from the next state:
  - `qsfp_resetl`=1 only in INIT and ACTIVE.
  - `qsfp_lpmode`=0 only in ACTIVE.
  - `qsfp_modsell`=0 only in INIT and ACTIVE.
  - `mac_rst`=0 only in ACTIVE.
  - `cfg_tx_enable` = `cfg_rx_enable` = `lane_enable` in ACTIVE, else 0.
  - `link_up` = `rx_status_s & lane_enable` in ACTIVE, else 0.
  - `int_event` pulses for one cycle on a 1->0 edge of synced IntL while in ACTIVE; edges in any other state are ignored.

## Timing
- While `rst_n`=0, all outputs are held at reset values: state=DISABLED, `present`=0, `qsfp_resetl`=0, `qsfp_lpmode`=1, `qsfp_modsell`=1, `mac_rst`=1, all enables/`link_up`=0, `int_event`=0. Deasserting `rst_n` mid-sequence always restarts from DISABLED.
- A ModPrsL falling edge held low sets `present` 2+DEBOUNCE_CYCLES cycles later.
- Entry into RESET occurs the cycle after `present` rises, provided `enable`=1.
- RESET lasts exactly RESET_CYCLES cycles; INIT lasts exactly INIT_CYCLES cycles. Pin outputs change on the same edge as `state`.
- Module removal drives ACTIVE -> ABSENT one cycle after `present` falls. Outputs return to safe values on that same edge.
- `restart` coincident with a timer reaching 0 takes priority and reloads the timer.
- A presence glitch shorter than DEBOUNCE_CYCLES produces no `present` change.
- `rx_status` to `link_up` latency: 3 cycles (2 sync + 1 register).

## Test plan
- Reset and insert: assert `rst_n` low and check all reset values. Release with `enable`=1 and ModPrsL=0, using DEBOUNCE=4, RESET=8, INIT=16. Required: RESET entered at cycle 7 after release, `qsfp_resetl` low for exactly 8 cycles, INIT for 16 cycles, then ACTIVE with `mac_rst`=0 and `qsfp_lpmode`=0.
- Glitch rejection: ModPrsL low for 3 cycles (DEBOUNCE=4). Required: `present` stays 0, state stays ABSENT.
- Hot removal in ACTIVE: raise ModPrsL. Required: `present` falls after 6 cycles, next cycle state=ABSENT, `cfg_tx_enable`=0, `qsfp_resetl`=0, `mac_rst`=1.
- Restart in INIT at timer=0, then `enable`=0 mid-RESET. Required: the restart returns state to RESET with a full 8-cycle hold; `enable`=0 then forces DISABLED on the next edge.
- Lane mask: in ACTIVE with `lane_enable`=4'b0101 and `rx_status`=4'b1111. Required: `cfg_tx_enable`=`cfg_rx_enable`=4'b0101 and `link_up`=4'b0101 after 3 cycles.
- Interrupt: IntL falling in ACTIVE gives exactly one `int_event` pulse 3 cycles later. An IntL falling edge in INIT gives no pulse.
